// File: rtl/aes_cone_match_pipe_pkg.sv
// Shared types, default sizing and parameter checks for the AES cone match pipeline.
package aes_cone_pkg;

   localparam int DEF_WIDTH    = 12;
   localparam int DEF_CHANNELS = 4;
   localparam int DEF_STAGES   = 2;
   localparam int DEF_CNT_W    = 8;

   // Stage payload at default channel count; the top re-declares it at its own CHANNELS.
   typedef struct packed {
      logic [DEF_CHANNELS-1:0] match;
      logic [DEF_CHANNELS-1:0] side_a;
      logic [DEF_CHANNELS-1:0] side_b;
   } cone_beat_t;

   function automatic bit stages_legal(input int stages);
      return (stages >= 1) && (stages <= 4);
   endfunction

endpackage

// File: rtl/aes_cone_match_pipe_if.sv
// Config, input-beat, output-beat and counter signals of the cone match pipeline.
interface aes_cone_match_pipe_if
   import aes_cone_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int CHANNELS = DEF_CHANNELS,
   parameter int CNT_W    = DEF_CNT_W
);
   logic                      cfg_we;
   logic [WIDTH-1:0]          cfg_pattern;
   logic [WIDTH-1:0]          cfg_mask;
   logic                      in_valid;
   logic                      in_ready;
   logic [CHANNELS*WIDTH-1:0] in_data;
   logic [CHANNELS-1:0]       in_side_a;
   logic [CHANNELS-1:0]       in_side_b;
   logic                      out_valid;
   logic                      out_ready;
   logic [CHANNELS-1:0]       out_y;
   logic [CHANNELS-1:0]       out_match;
   logic [CHANNELS*CNT_W-1:0] hit_cnt;
   logic                      cnt_clr;

   modport slave (
      input  cfg_we, cfg_pattern, cfg_mask,
      input  in_valid, in_data, in_side_a, in_side_b,
      output in_ready,
      output out_valid, out_y, out_match,
      input  out_ready,
      output hit_cnt,
      input  cnt_clr
   );

   modport master (
      output cfg_we, cfg_pattern, cfg_mask,
      output in_valid, in_data, in_side_a, in_side_b,
      input  in_ready,
      input  out_valid, out_y, out_match,
      output out_ready,
      input  hit_cnt,
      output cnt_clr
   );
endinterface

// File: rtl/aes_cone_match_pipe_stage.sv
// One valid/ready register slice; accepts when empty or when its contents are leaving.
module aes_cone_pipe_stage #(
   parameter type dat_t = logic
) (
   input  logic clk,
   input  logic rst,
   input  logic in_vld_i,
   output logic in_rdy_o,
   input  dat_t in_dat_i,
   output logic out_vld_o,
   input  logic out_rdy_i,
   output dat_t out_dat_o
);
   logic full_q, full_d;
   dat_t dat_q, dat_d;

   assign in_rdy_o  = ~full_q | out_rdy_i;
   assign out_vld_o = full_q;
   assign out_dat_o = dat_q;

   always_comb begin
      full_d = full_q;
      dat_d  = dat_q;
      if (in_rdy_o) begin
         full_d = in_vld_i;
         if (in_vld_i) dat_d = in_dat_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_q <= 1'b0;
         dat_q  <= '0;
      end else begin
         full_q <= full_d;
         dat_q  <= dat_d;
      end
   end
endmodule

// File: rtl/aes_cone_match_pipe.sv
// Per-channel masked match plus AOI22 reduction through a STAGES-deep valid/ready pipe,
// with per-channel saturating hit counters on output transfers.
module aes_cone_match_pipe
   import aes_cone_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int CHANNELS = DEF_CHANNELS,
   parameter int STAGES   = DEF_STAGES,
   parameter int CNT_W    = DEF_CNT_W
) (
   input logic                  clk,
   input logic                  rst,
   aes_cone_match_pipe_if.slave bus
);
   typedef struct packed {
      logic [CHANNELS-1:0] match;
      logic [CHANNELS-1:0] side_a;
      logic [CHANNELS-1:0] side_b;
   } beat_t;

   typedef struct packed {
      logic [CHANNELS-1:0] match;
      logic [CHANNELS-1:0] y;
   } fin_t;

   if (!stages_legal(STAGES)) begin : g_bad_stages
      $error("aes_cone_match_pipe: STAGES must be within 1..4");
   end

   logic [WIDTH-1:0] cfg_pattern_q, cfg_mask_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cfg_pattern_q <= '0;
         cfg_mask_q    <= '0;
      end else if (bus.cfg_we) begin
         cfg_pattern_q <= bus.cfg_pattern;
         cfg_mask_q    <= bus.cfg_mask;
      end
   end

   // Compare uses the registered config, so a same-edge cfg_we only affects later beats.
   beat_t in_beat;
   always_comb begin
      in_beat = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         in_beat.match[c] = ((bus.in_data[c*WIDTH +: WIDTH] ^ cfg_pattern_q) & cfg_mask_q) == '0;
      end
      in_beat.side_a = bus.in_side_a;
      in_beat.side_b = bus.in_side_b;
   end

   logic [STAGES:0]   vld;
   logic [STAGES-1:0] rdy;
   beat_t             dat [STAGES];
   fin_t              fin_in, fin_q;

   assign dat[0]       = in_beat;
   // Only take a beat when every stage is guaranteed to move or the tail is free.
   assign bus.in_ready = rdy[0] & (~vld[STAGES] | bus.out_ready);
   assign vld[0]       = bus.in_valid & bus.in_ready;

   for (genvar s = 0; s < STAGES-1; s++) begin : g_mid
      aes_cone_pipe_stage #(.dat_t(beat_t)) u_stage (
         .clk       (clk),
         .rst       (rst),
         .in_vld_i  (vld[s]),
         .in_rdy_o  (rdy[s]),
         .in_dat_i  (dat[s]),
         .out_vld_o (vld[s+1]),
         .out_rdy_i (rdy[s+1]),
         .out_dat_o (dat[s+1])
      );
   end

   always_comb begin
      fin_in.match = dat[STAGES-1].match;
      fin_in.y     = ~((dat[STAGES-1].side_a & dat[STAGES-1].side_b) | dat[STAGES-1].match);
   end

   aes_cone_pipe_stage #(.dat_t(fin_t)) u_last (
      .clk       (clk),
      .rst       (rst),
      .in_vld_i  (vld[STAGES-1]),
      .in_rdy_o  (rdy[STAGES-1]),
      .in_dat_i  (fin_in),
      .out_vld_o (vld[STAGES]),
      .out_rdy_i (bus.out_ready),
      .out_dat_o (fin_q)
   );

   assign bus.out_valid = vld[STAGES];
   assign bus.out_match = fin_q.match;
   assign bus.out_y     = fin_q.y;

   logic             out_xfer;
   logic [CNT_W-1:0] cnt_q [CHANNELS];
   logic [CNT_W-1:0] cnt_d [CHANNELS];

   assign out_xfer = vld[STAGES] & bus.out_ready;

   always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
         cnt_d[c] = cnt_q[c];
         if (bus.cnt_clr)
            cnt_d[c] = '0;
         else if (out_xfer && fin_q.match[c] && (cnt_q[c] != {CNT_W{1'b1}}))
            cnt_d[c] = cnt_q[c] + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < CHANNELS; c++) cnt_q[c] <= '0;
      end else begin
         for (int c = 0; c < CHANNELS; c++) cnt_q[c] <= cnt_d[c];
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_cnt_out
      assign bus.hit_cnt[c*CNT_W +: CNT_W] = cnt_q[c];
   end
endmodule

// File: tb/tb_aes_cone_match_pipe.sv
// Directed bench with scoreboard for aes_cone_match_pipe (STAGES=2, CNT_W=2).
module tb_aes_cone_match_pipe;
   import aes_cone_pkg::*;

   localparam int WIDTH    = 12;
   localparam int CHANNELS = 4;
   localparam int STAGES   = 2;
   localparam int CNT_W    = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   aes_cone_match_pipe_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .CNT_W(CNT_W)) bus ();

   aes_cone_match_pipe #(
      .WIDTH(WIDTH), .CHANNELS(CHANNELS), .STAGES(STAGES), .CNT_W(CNT_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [CHANNELS-1:0] match;
      logic [CHANNELS-1:0] y;
   } exp_t;

   exp_t             sb [$];
   exp_t             mon_e;
   int               tests = 0;
   int               fails = 0;
   int               outs  = 0;
   logic [WIDTH-1:0] m_pat  = '0;
   logic [WIDTH-1:0] m_mask = '0;
   logic [CNT_W-1:0] m_cnt [CHANNELS];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [CHANNELS*WIDTH-1:0] d,
                                  input logic [CHANNELS-1:0] a, input logic [CHANNELS-1:0] b);
      exp_t e;
      for (int c = 0; c < CHANNELS; c++) begin
         e.match[c] = (((d[c*WIDTH +: WIDTH] ^ m_pat) & m_mask) == '0);
         e.y[c]     = ~((a[c] & b[c]) | e.match[c]);
      end
      return e;
   endfunction

   function automatic logic [CHANNELS*CNT_W-1:0] pack_cnt();
      logic [CHANNELS*CNT_W-1:0] p;
      for (int c = 0; c < CHANNELS; c++) p[c*CNT_W +: CNT_W] = m_cnt[c];
      return p;
   endfunction

   function automatic logic [CHANNELS*WIDTH-1:0] bdata(input int idx);
      logic [CHANNELS*WIDTH-1:0] d;
      for (int c = 0; c < CHANNELS; c++)
         d[c*WIDTH +: WIDTH] = (((idx + c) % 2) == 1) ? 12'hA5C : 12'(256 + idx);
      return d;
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input logic [CHANNELS*WIDTH-1:0] d,
                        input logic [CHANNELS-1:0] a, input logic [CHANNELS-1:0] b);
      bus.in_valid  = 1'b1;
      bus.in_data   = d;
      bus.in_side_a = a;
      bus.in_side_b = b;
   endtask

   task automatic send(input logic [CHANNELS*WIDTH-1:0] d,
                       input logic [CHANNELS-1:0] a, input logic [CHANNELS-1:0] b);
      int waitc = 0;
      drive(d, a, b);
      @(negedge clk);
      while (!bus.in_ready && waitc < 50) begin
         @(negedge clk);
         waitc++;
      end
      check("accept_wait", 32'(waitc < 50), 1);
      if (waitc < 50) sb.push_back(model(d, a, b));
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || bus.out_valid) && n < 50) begin
         step(1);
         n++;
      end
      check("drain_left", sb.size(), 0);
   endtask

   // Output monitor: pops on each transfer and tracks the expected hit counters.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.out_valid && bus.out_ready) begin
            outs++;
            check("out_expected", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
               mon_e = sb.pop_front();
               check("out_match", bus.out_match, mon_e.match);
               check("out_y", bus.out_y, mon_e.y);
               for (int c = 0; c < CHANNELS; c++)
                  if (!bus.cnt_clr && mon_e.match[c] && m_cnt[c] != {CNT_W{1'b1}})
                     m_cnt[c] = m_cnt[c] + 1'b1;
            end
         end
         if (bus.cnt_clr)
            for (int c = 0; c < CHANNELS; c++) m_cnt[c] = '0;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int idx;
      int outs0;
      logic [CHANNELS-1:0] snap_y, snap_m;

      rst = 1'b1;
      bus.cfg_we = 1'b0;  bus.cfg_pattern = '0;  bus.cfg_mask = '0;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_side_a = '0; bus.in_side_b = '0;
      bus.out_ready = 1'b1; bus.cnt_clr = 1'b0;
      for (int c = 0; c < CHANNELS; c++) m_cnt[c] = '0;
      step(2);
      rst = 1'b0;
      step(1);

      check("rst_out_valid", bus.out_valid, 0);
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_hit_cnt", bus.hit_cnt, 0);
      check("rst_out_y", bus.out_y, 0);
      check("rst_out_match", bus.out_match, 0);

      bus.cfg_we = 1'b1; bus.cfg_pattern = 12'hA5C; bus.cfg_mask = 12'hFFF;
      step(1);
      bus.cfg_we = 1'b0; m_pat = 12'hA5C; m_mask = 12'hFFF;

      // Basic match on channel 0 and latency of STAGES-1 edges after acceptance.
      send({12'h000, 12'h000, 12'h000, 12'hA5C}, 4'b0000, 4'b0000);
      check("lat_early", bus.out_valid, 0);
      step(1);
      check("lat_valid", bus.out_valid, 1);
      check("t1_match0", bus.out_match[0], 1);
      check("t1_y0", bus.out_y[0], 0);
      step(1);
      check("t1_hit_cnt", bus.hit_cnt, pack_cnt());
      check("t1_hit0", bus.hit_cnt[CNT_W-1:0], 1);

      // Channel 1 mismatch with partial and full AND term.
      send({12'h000, 12'h000, 12'hA5D, 12'h000}, 4'b0010, 4'b0000);
      send({12'h000, 12'h000, 12'hA5D, 12'h000}, 4'b0010, 4'b0010);
      drain();

      // Backpressure: stall output, stream six beats.
      bus.out_ready = 1'b0;
      acc = 0;
      idx = 0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         drive(bdata(idx), 4'(idx), 4'(idx * 3));
         @(negedge clk);
         if (bus.in_ready) begin
            sb.push_back(model(bdata(idx), 4'(idx), 4'(idx * 3)));
            idx++;
            acc++;
         end
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      check("stall_accepted", acc, STAGES);
      check("stall_in_ready", bus.in_ready, 0);
      check("stall_out_valid", bus.out_valid, 1);
      snap_y = bus.out_y;
      snap_m = bus.out_match;
      step(3);
      check("stall_hold_y", bus.out_y, snap_y);
      check("stall_hold_match", bus.out_match, snap_m);
      outs0 = outs;
      bus.out_ready = 1'b1;
      while (idx < 6) begin
         send(bdata(idx), 4'(idx), 4'(idx * 3));
         idx++;
      end
      drain();
      check("stream_count", outs - outs0, 6);

      // Config write on the same edge as a beat acceptance.
      bus.cfg_we = 1'b1; bus.cfg_pattern = 12'h000; bus.cfg_mask = 12'hFFF;
      send({12'h000, 12'h000, 12'h000, 12'hA5C}, 4'b0000, 4'b0000);
      bus.cfg_we = 1'b0; m_pat = 12'h000;
      send({12'h000, 12'h000, 12'h000, 12'hA5C}, 4'b0000, 4'b0000);
      drain();

      // Counter clear, saturation, and clear winning over an increment.
      bus.cnt_clr = 1'b1;
      step(1);
      bus.cnt_clr = 1'b0;
      check("clr_idle", bus.hit_cnt, 0);
      for (int i = 0; i < 5; i++) send('0, 4'b0000, 4'b0000);
      drain();
      check("sat_hit_cnt", bus.hit_cnt, pack_cnt());
      check("sat_hit0", bus.hit_cnt[CNT_W-1:0], 3);
      send('0, 4'b0000, 4'b0000);
      step(1);
      check("clr_xfer_valid", bus.out_valid, 1);
      bus.cnt_clr = 1'b1;
      step(1);
      bus.cnt_clr = 1'b0;
      check("clr_with_xfer", bus.hit_cnt, 0);
      drain();

      // Asynchronous reset with two beats in flight.
      bus.out_ready = 1'b0;
      send(bdata(7), 4'b0001, 4'b0001);
      send(bdata(8), 4'b0010, 4'b0010);
      check("pre_rst_valid", bus.out_valid, 1);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_valid", bus.out_valid, 0);
      check("async_rst_match", bus.out_match, 0);
      sb.delete();
      for (int c = 0; c < CHANNELS; c++) m_cnt[c] = '0;
      m_pat = '0;
      m_mask = '0;
      step(1);
      rst = 1'b0;
      bus.out_ready = 1'b1;
      outs0 = outs;
      step(5);
      check("rst_no_ghost", outs - outs0, 0);
      check("rst_hit_zero", bus.hit_cnt, 0);
      send({12'h3C7, 12'h123, 12'hFFF, 12'h001}, 4'b0101, 4'b0011);
      step(1);
      check("cfg_zero_match", bus.out_match, 4'hF);
      drain();
      check("final_hit_cnt", bus.hit_cnt, pack_cnt());

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/aes_cone_match_pipe.md
Name: aes_cone_match_pipe

Overview:
Parametrised, pipelined successor to the single-output AES timing-cone decoders. It evaluates a programmable masked-pattern match per channel, then an AOI22-style final reduction: y = ~((side_a & side_b) | match). Inputs and results move through a valid/ready pipeline with backpressure. Per-channel saturating hit counters support timing-cone characterisation runs.

Parameters:
WIDTH, 12, data bits per channel fed to the match term
CHANNELS, 4, independent cones evaluated in parallel
STAGES, 2, pipeline register stages from input accept to output (legal values 1..4)
CNT_W, 8, width of each per-channel hit counter

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
cfg_we  input  1  load pattern/mask registers
cfg_pattern  input  WIDTH  compare pattern, shared by all channels
cfg_mask  input  WIDTH  care mask, where 1 means the bit is compared
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat
in_data  input  CHANNELS*WIDTH  channel c is in_data[c*WIDTH +: WIDTH]
in_side_a  input  CHANNELS  AND-term operand A per channel
in_side_b  input  CHANNELS  AND-term operand B per channel
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result
out_y  output  CHANNELS  per-channel y
out_match  output  CHANNELS  per-channel raw match bit
hit_cnt  output  CHANNELS*CNT_W  saturating count of accepted beats with match=1
cnt_clr  input  1  synchronous clear of all hit counters

Behaviour:
- Reset: asserting rst asynchronously clears every stage valid bit, out_valid, out_y, out_match, hit_cnt, cfg_pattern_q and cfg_mask_q. With mask=0 every beat matches.
- Reset mid-operation: in-flight beats are discarded and no output beat is produced for them.
- Match: match[c] = ((in_data_c ^ cfg_pattern_q) & cfg_mask_q) == 0. Match is computed in stage 1 from the input beat and the registered config.
- Config timing: cfg_we writes the registers at the clock edge. A beat accepted on the same edge uses the old config. A beat accepted on any later edge uses the new config.
- Final reduction: y[c] = ~((side_a[c] & side_b[c]) | match[c]). It is registered in stage STAGES. Stages between 1 and STAGES carry {match, side_a, side_b} unchanged.
- Latency: a beat accepted at edge k appears on out_valid/out_y after edge k+STAGES-1 when there is no stall. With STAGES=1, it appears after the accepting edge.
- Handshake: transfers happen on (valid & ready) at a clock edge. out_* must hold stable while out_valid=1 and out_ready=0.
- in_ready = ~stage_full[last] | out_ready. Each stage advances when its successor is empty or advancing, so bubbles collapse and throughput is one beat per cycle under continuous out_ready.
- in_ready must not depend combinationally on in_valid.
- Full pipeline with out_ready=0: in_ready=0 and all stage contents hold.
- Full pipeline with out_ready=1 and in_valid=1 in the same cycle: one beat leaves, one beat enters, and occupancy is unchanged.
- Hit counters: hit_cnt[c] increments by 1 when an output beat transfers with out_match[c]=1. At 2^CNT_W-1 it saturates and does not wrap.
- cnt_clr has priority over a simultaneous increment; the count becomes 0.

Decomposition:
- Shared package aes_cone_pkg holds:
  - the stage payload typedef (match, side_a, side_b per channel)
  - the default WIDTH, CHANNELS and STAGES constants
  - the legal-STAGES check function
- One sub-module, aes_cone_pipe_stage: a single valid/ready register slice, instantiated STAGES times through generate.
- The match compare and the counters stay in the top level.

Test Plan:
- Reset then cfg_mask=0xFFF, cfg_pattern=0xA5C, one beat with channel0 data 0xA5C and side_a=side_b=0, STAGES=2 -> out_valid one edge after acceptance, out_match[0]=1, out_y[0]=0, hit_cnt[0]=1.
- Channel1 data 0xA5D, side_a[1]=1, side_b[1]=0 -> out_match[1]=0, out_y[1]=1. Then side_a[1]=side_b[1]=1 -> out_y[1]=0.
- Stream 6 beats with out_ready=0 -> in_ready drops after STAGES beats are accepted and out_* stays stable. Release out_ready -> all beats emerge in order with no loss or duplication.
- cfg_we on the same edge a beat is accepted, new pattern 0x000 -> that beat uses old pattern 0xA5C and the next beat uses 0x000.
- CNT_W=2 with 5 matching beats -> hit_cnt saturates at 3. Assert cnt_clr together with a matching transfer -> hit_cnt=0.
- Assert rst with 2 beats in flight -> out_valid=0 immediately (asynchronous), no beat emerges after release, and config reads back as 0.
